bus_master_arbiter: RTL and testbench
=====================================

// Module: bus_master_arbiter
// PURPOSE
//  Shares the single external APB-style bus (addr/select/enable/write/wdata/rdata/ready) between NUM_MASTERS
//  bus masters (bus access unit, debug/DMA ports). Masters request with req/gnt; owner keeps the bus for a
//  whole cache-line burst and releases it by dropping req. Round-robin among waiting masters, no starvation.
// PARAMETERS
//  NUM_MASTERS     2    number of requesting masters (2..8)
//  TIMEOUT_CYCLES  256  access-phase watchdog limit (used only with BUS_ARB_WATCHDOG_EN)
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous, active-high reset
//  mReq         in   N        per-master bus request; held high for the whole burst
//  mGnt         out  N        per-master grant, one-hot or zero
//  mAddr        in   N x 32   per-master address
//  mSelect      in   N        per-master select
//  mEnable      in   N        per-master enable
//  mWrite       in   N        per-master write
//  mWdata       in   N x 32   per-master write data
//  mRdata       out  32       read data, broadcast to all masters
//  mReady       out  N        per-master ready (only owner may see 1)
//  mErr         out  N        per-master timeout error pulse (0 without BUS_ARB_WATCHDOG_EN)
//  addr/select/enable/write/wdata  out  32/1/1/1/32   slave-side bus
//  rdata        in   32       slave read data
//  ready        in   1        slave ready
// BEHAVIOUR
//  - Reset: state=ARB_IDLE, mGnt=0, rrPtr=0, select/enable/write=0, addr/wdata=0, mReady=0, mErr=0, watchdog=0.
//  - States: ARB_IDLE (no owner), ARB_OWNED (owner registered), ARB_RELEASE (one dead cycle after owner drop).
//  - ARB_IDLE: if any mReq, winner = first set bit at or after rrPtr (wrapping N-1 -> 0); owner<=winner,
//    mGnt[winner]<=1 next cycle (1-cycle req->gnt latency); none set -> stay.
//  - ARB_OWNED: slave bus = owner's mAddr/mSelect/mEnable/mWrite/mWdata, combinational; mReady[owner]=ready.
//    Non-owners: mGnt=0, mReady=0, their select/enable ignored. Owner may only drive select while mGnt=1.
//  - Release: owner drops mReq while its select=0 -> ARB_RELEASE; mGnt=0, rrPtr<=owner+1 (mod N).
//    Owner drops mReq while select=1 (mid-access) -> ignored until the access completes (ready=1), then release.
//  - ARB_RELEASE: bus outputs forced 0 for one cycle; next cycle arbitrate as in ARB_IDLE (no back-to-back
//    grant without the idle cycle, guaranteeing select low between owners).
//  - Simultaneous requests: round-robin order from rrPtr; owner re-requesting immediately after release waits
//    behind any other pending requester.
//  - Reset mid-burst: all grants drop next edge, slave select/enable low, burst abandoned (masters also reset).
//  - Bus outputs when no owner: addr=0, wdata=0, select=enable=write=0. mRdata=rdata always.
// CONFIGURATION
//  BUS_ARB_WATCHDOG_EN defined: counter clears on each cycle with enable=0 or ready=1; increments while
//    owner enable=1 and ready=0. On reaching TIMEOUT_CYCLES-1: mReady[owner]=1, mErr[owner]=1 for one cycle,
//    mRdata=32'hDEAD_BEEF that cycle, slave select/enable forced 0 that cycle; owner keeps grant.
//  Not defined: no counter, mErr tied 0, access waits on ready forever.
// STRUCTURE
//  - Shared package BusArbiterTypes: ArbState enum {ARB_IDLE=2'h0, ARB_OWNED=2'h1, ARB_RELEASE=2'h2},
//    BUS_ERR_RDATA constant, master-index typedef logic [$clog2(NUM_MASTERS)-1:0].
//  - One sub-module: rr_priority_picker (N-bit request vector + rrPtr -> valid + winner index, combinational).
//  - Owner mux, FSM, rrPtr, watchdog in this module.
// TESTING
//  - Single master 0: mReq[0]=1 at cycle 0 -> mGnt[0]=1 at cycle 1; 4-word read burst, ready=1 each access
//    -> mRdata matches slave, mReady[0] only in access cycles; drop mReq -> mGnt=0 next cycle.
//  - Both mReq at reset exit -> master 0 granted; on release 1 cycle select=0, then master 1 granted.
//  - Master 0 releases and re-requests same cycle while master 1 waiting -> master 1 granted first.
//  - Owner drops mReq during access with ready=0 for 3 cycles -> grant held until ready=1, then release.
//  - Non-owner drives select=1/enable=1 -> slave select unaffected, its mReady stays 0.
//  - BUS_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=8, ready stuck 0 -> 8th access cycle mErr=1, mReady=1,
//    mRdata=32'hDEAD_BEEF, select forced 0; without macro, access still pending after 1000 cycles.

Source files
------------

// File: rtl/bus_master_arbiter_pkg.sv
// Shared types for the bus master arbiter: FSM state encoding, error read data
// and the helper that sizes master-index fields.
package bus_master_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'h0,
        ARB_OWNED   = 2'h1,
        ARB_RELEASE = 2'h2
    } ArbState;

    localparam logic [31:0] BUS_ERR_RDATA = 32'hDEAD_BEEF;

    // Width of a master index; never below one bit.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_master_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping from the top index back to 0.
module rr_priority_picker
    import bus_master_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned IDX_W       = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic                   valid,
    output logic [IDX_W-1:0]       winner
);

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        // Upper pass covers rr_ptr..N-1, lower pass wraps to 0..rr_ptr-1.
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!valid && req[i] && (IDX_W'(i) >= rr_ptr)) begin
                valid  = 1'b1;
                winner = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!valid && req[i]) begin
                valid  = 1'b1;
                winner = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter sharing one APB-style slave bus between NUM_MASTERS masters.
// Optional access watchdog enabled by defining BUS_ARB_WATCHDOG_EN.
module bus_master_arbiter
    import bus_master_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    mReq,
    output logic [NUM_MASTERS-1:0]    mGnt,
    input  logic [NUM_MASTERS*32-1:0] mAddr,
    input  logic [NUM_MASTERS-1:0]    mSelect,
    input  logic [NUM_MASTERS-1:0]    mEnable,
    input  logic [NUM_MASTERS-1:0]    mWrite,
    input  logic [NUM_MASTERS*32-1:0] mWdata,
    output logic [31:0]               mRdata,
    output logic [NUM_MASTERS-1:0]    mReady,
    output logic [NUM_MASTERS-1:0]    mErr,
    output logic [31:0]               addr,
    output logic                      select,
    output logic                      enable,
    output logic                      write,
    output logic [31:0]               wdata,
    input  logic [31:0]               rdata,
    input  logic                      ready
);

    localparam int unsigned IDX_W = idx_width(NUM_MASTERS);
    typedef logic [IDX_W-1:0] idx_t;

    ArbState state_q, state_d;
    idx_t    owner_q, owner_d;
    idx_t    rr_ptr_q, rr_ptr_d;

    logic        pick_valid;
    idx_t        pick_idx;
    logic        own_req, own_sel, own_en, own_wr;
    logic [31:0] own_addr, own_wdata;
    logic        timeout;

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req    (mReq),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    always_comb begin
        own_req   = mReq[owner_q];
        own_sel   = mSelect[owner_q];
        own_en    = mEnable[owner_q];
        own_wr    = mWrite[owner_q];
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner_q == idx_t'(i)) begin
                own_addr  = mAddr[i*32 +: 32];
                own_wdata = mWdata[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            // The release cycle arbitrates like idle, so exactly one dead cycle separates owners.
            ARB_IDLE, ARB_RELEASE: begin
                if (pick_valid) begin
                    state_d = ARB_OWNED;
                    owner_d = pick_idx;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_OWNED: begin
                // A dropped request is honoured only once any access in flight has completed.
                if (!own_req && (!own_sel || (own_en && ready) || timeout)) begin
                    state_d  = ARB_RELEASE;
                    rr_ptr_d = (owner_q == idx_t'(NUM_MASTERS - 1)) ? '0 : owner_q + idx_t'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        mGnt   = '0;
        mReady = '0;
        mErr   = '0;
        addr   = '0;
        wdata  = '0;
        select = 1'b0;
        enable = 1'b0;
        write  = 1'b0;
        if (state_q == ARB_OWNED) begin
            mGnt[owner_q]   = 1'b1;
            mReady[owner_q] = ready | timeout;
            mErr[owner_q]   = timeout;
            addr            = own_addr;
            wdata           = own_wdata;
            write           = own_wr;
            select          = own_sel & ~timeout;
            enable          = own_en & ~timeout;
        end
        mRdata = timeout ? BUS_ERR_RDATA : rdata;
    end

`ifdef BUS_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    always_comb begin
        wd_cnt_d = '0;
        timeout  = 1'b0;
        if ((state_q == ARB_OWNED) && own_en && !ready) begin
            if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    logic unused_timeout_cycles;

    assign timeout               = 1'b0;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Self-checking bench for bus_master_arbiter: table-driven burst, directed corner
// sequences, then randomized traffic against a behavioural round-robin model.
module tb_bus_master_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned TO = 8;
`ifdef BUS_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, sel, en, wr;
    logic [N*32-1:0] maddr, mwdata;
    logic [N-1:0]    gnt, mready, merr;
    logic [31:0]     mrdata, addr, wdata, rdata;
    logic            select, enable, write, ready;

    int n_checks = 0;
    int n_errors = 0;

    bus_master_arbiter #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mReq    (req),
        .mGnt    (gnt),
        .mAddr   (maddr),
        .mSelect (sel),
        .mEnable (en),
        .mWrite  (wr),
        .mWdata  (mwdata),
        .mRdata  (mrdata),
        .mReady  (mready),
        .mErr    (merr),
        .addr    (addr),
        .select  (select),
        .enable  (enable),
        .write   (write),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic        s0, e0, s1, e1, rdy;
        logic [31:0] a0, rd;
        logic [2:0]  x_gnt;
        logic        x_sel, x_en;
        logic [2:0]  x_rdy;
        logic [31:0] x_addr, x_rd;
    } vec_t;

    function automatic vec_t mk(logic [2:0] rq, logic s0, logic e0, logic s1, logic e1,
                                logic rdy, logic [31:0] a0, logic [31:0] rd, logic [2:0] xg,
                                logic xs, logic xe, logic [2:0] xr, logic [31:0] xa);
        vec_t v;
        v.req = rq; v.s0 = s0; v.e0 = e0; v.s1 = s1; v.e1 = e1; v.rdy = rdy;
        v.a0 = a0; v.rd = rd; v.x_gnt = xg; v.x_sel = xs; v.x_en = xe; v.x_rdy = xr;
        v.x_addr = xa; v.x_rd = rd;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        req = '0; sel = '0; en = '0; wr = '0;
        maddr = '0; mwdata = '0; rdata = '0; ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic bit_of(logic [N-1:0] v, int i);
        return |(v & (N'(1) << i));
    endfunction

    // Behavioural model: current owner (-1 = none), round-robin start, stall run length.
    int m_owner, m_rr, m_wd;

    initial begin
        vec_t tbl[$];
        rst = 1'b1;
        idle_inputs();

        // Single-master burst on master 0 with master 1 poking select/enable without a request.
        tbl.push_back(mk(3'b001, 0, 0, 0, 0, 0, 32'h0, 32'h1111_0000, 3'b000, 0, 0, 3'b000, 32'h0));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(3'b001, 1, 0, 0, 0, 0, 32'h100 + 32'(4*k), 32'h5555_0000 + 32'(k),
                             3'b001, 1, 0, 3'b000, 32'h100 + 32'(4*k)));
            tbl.push_back(mk(3'b001, 1, 1, 0, 0, 1, 32'h100 + 32'(4*k), 32'hA000_0000 + 32'(k),
                             3'b001, 1, 1, 3'b001, 32'h100 + 32'(4*k)));
        end
        tbl.push_back(mk(3'b001, 0, 0, 1, 1, 0, 32'h200, 32'h2222_2222, 3'b001, 0, 0, 3'b000,
                         32'h200));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 32'h0, 32'h3333_3333, 3'b001, 0, 0, 3'b000, 32'h0));
        tbl.push_back(mk(3'b000, 0, 0, 1, 1, 1, 32'h300, 32'h4444_4444, 3'b000, 0, 0, 3'b000, 32'h0));

        do_reset();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_select", 32'({select, enable, write}), 32'h0);
        chk("reset_addr", addr, 32'h0);
        chk("reset_ready_err", 32'({mready, merr}), 32'h0);

        for (int r = 0; r < tbl.size(); r++) begin
            req = tbl[r].req;
            sel = {1'b0, tbl[r].s1, tbl[r].s0};
            en  = {1'b0, tbl[r].e1, tbl[r].e0};
            maddr = {32'h0, 32'hBAD0_0000, tbl[r].a0};
            rdata = tbl[r].rd;
            ready = tbl[r].rdy;
            settle();
            chk($sformatf("tbl%0d_gnt", r), 32'(gnt), 32'(tbl[r].x_gnt));
            chk($sformatf("tbl%0d_select", r), 32'(select), 32'(tbl[r].x_sel));
            chk($sformatf("tbl%0d_enable", r), 32'(enable), 32'(tbl[r].x_en));
            chk($sformatf("tbl%0d_mready", r), 32'(mready), 32'(tbl[r].x_rdy));
            chk($sformatf("tbl%0d_addr", r), addr, tbl[r].x_addr);
            chk($sformatf("tbl%0d_rdata", r), mrdata, tbl[r].x_rd);
            tick();
        end

        // Both request at reset exit: master 0 first, one dead cycle, then master 1.
        do_reset();
        req = 3'b011;
        settle();
        chk("both_c0_gnt", 32'(gnt), 32'h0);
        tick();
        chk("both_c1_gnt", 32'(gnt), 32'b001);
        req = 3'b010;
        settle();
        chk("both_drop_gnt", 32'(gnt), 32'b001);
        tick();
        chk("both_dead_gnt", 32'(gnt), 32'h0);
        chk("both_dead_select", 32'(select), 32'h0);
        tick();
        chk("both_m1_gnt", 32'(gnt), 32'b010);

        // Master 0 releases and re-requests at once while master 1 waits.
        do_reset();
        req = 3'b011;
        tick();
        chk("rereq_own_gnt", 32'(gnt), 32'b001);
        req = 3'b010;
        tick();
        req = 3'b011;
        settle();
        chk("rereq_dead_gnt", 32'(gnt), 32'h0);
        tick();
        chk("rereq_m1_first", 32'(gnt), 32'b010);
        req = 3'b001;
        tick();
        tick();
        chk("rereq_m0_after", 32'(gnt), 32'b001);

        // Request dropped mid-access: grant holds through three wait states.
        do_reset();
        req = 3'b001;
        tick();
        sel = 3'b001;
        maddr = {64'h0, 32'h0000_0ABC};
        tick();
        en = 3'b001;
        req = 3'b000;
        for (int w = 0; w < 3; w++) begin
            settle();
            chk($sformatf("midacc_wait%0d_gnt", w), 32'(gnt), 32'b001);
            chk($sformatf("midacc_wait%0d_mready", w), 32'(mready), 32'h0);
            tick();
        end
        ready = 1'b1;
        settle();
        chk("midacc_done_mready", 32'(mready), 32'b001);
        chk("midacc_done_select", 32'(select), 32'h1);
        tick();
        sel = '0; en = '0; ready = 1'b0;
        settle();
        chk("midacc_released_gnt", 32'(gnt), 32'h0);

        // Reset during a burst abandons the owner on the next edge.
        do_reset();
        req = 3'b001;
        tick();
        sel = 3'b001;
        en = 3'b001;
        rst = 1'b1;
        settle();
        chk("rstmid_before_gnt", 32'(gnt), 32'b001);
        tick();
        chk("rstmid_after_gnt", 32'(gnt), 32'h0);
        chk("rstmid_after_bus", 32'({select, enable}), 32'h0);
        rst = 1'b0;
        tick();
        chk("rstmid_regrant", 32'(gnt), 32'b001);

        // Slave stalls forever.
        do_reset();
        req = 3'b001;
        tick();
        sel = 3'b001;
        tick();
        en = 3'b001;
        rdata = 32'h1234_5678;
`ifdef BUS_ARB_WATCHDOG_EN
        for (int k = 1; k <= 8; k++) begin
            settle();
            if (k < 8) begin
                chk($sformatf("wd_cyc%0d_merr", k), 32'(merr), 32'h0);
                chk($sformatf("wd_cyc%0d_select", k), 32'(select), 32'h1);
            end else begin
                chk("wd_fire_merr", 32'(merr), 32'b001);
                chk("wd_fire_mready", 32'(mready), 32'b001);
                chk("wd_fire_rdata", mrdata, 32'hDEAD_BEEF);
                chk("wd_fire_bus", 32'({select, enable}), 32'h0);
                chk("wd_fire_gnt", 32'(gnt), 32'b001);
            end
            tick();
        end
        settle();
        chk("wd_after_merr", 32'(merr), 32'h0);
`else
        for (int k = 0; k < 1000; k++) tick();
        chk("stall_gnt", 32'(gnt), 32'b001);
        chk("stall_bus", 32'({select, enable}), 32'b11);
        chk("stall_ready_err", 32'({mready, merr}), 32'h0);
        chk("stall_rdata", mrdata, 32'h1234_5678);
`endif

        // Randomized traffic against the behavioural model.
        do_reset();
        m_owner = -1;
        m_rr = 0;
        m_wd = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        to, stall, found;
            int          o;
            logic [N-1:0] x_gnt, x_rdy, x_err;
            logic [31:0] x_addr, x_wdata;
            logic        x_sel, x_en, x_wr;

            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
                if ($urandom_range(3) == 0) en[i] = ~en[i];
            end
            sel    = N'($urandom);
            wr     = N'($urandom);
            maddr  = {$urandom, $urandom, $urandom};
            mwdata = {$urandom, $urandom, $urandom};
            rdata  = $urandom;
            ready  = ($urandom_range(3) == 0);
            rst    = ($urandom_range(255) == 0);
            settle();

            o = m_owner;
            to = 1'b0;
            x_gnt = '0; x_rdy = '0; x_err = '0;
            x_addr = '0; x_wdata = '0; x_sel = 1'b0; x_en = 1'b0; x_wr = 1'b0;
            if (o >= 0) begin
                to = WD && bit_of(en, o) && !ready && (m_wd == TO - 1);
                x_gnt   = N'(1) << o;
                x_rdy   = (ready || to) ? (N'(1) << o) : '0;
                x_err   = to ? (N'(1) << o) : '0;
                x_addr  = 32'(maddr >> (o * 32));
                x_wdata = 32'(mwdata >> (o * 32));
                x_sel   = bit_of(sel, o) && !to;
                x_en    = bit_of(en, o) && !to;
                x_wr    = bit_of(wr, o);
            end
            chk("rnd_gnt", 32'(gnt), 32'(x_gnt));
            chk("rnd_mready", 32'(mready), 32'(x_rdy));
            chk("rnd_merr", 32'(merr), 32'(x_err));
            chk("rnd_addr", addr, x_addr);
            chk("rnd_wdata", wdata, x_wdata);
            chk("rnd_ctrl", 32'({select, enable, write}), 32'({x_sel, x_en, x_wr}));
            chk("rnd_rdata", mrdata, to ? 32'hDEAD_BEEF : rdata);

            if (rst) begin
                m_owner = -1;
                m_rr = 0;
                m_wd = 0;
            end else begin
                stall = (o >= 0) && bit_of(en, o) && !ready;
                if (o >= 0) begin
                    if (!bit_of(req, o) &&
                        (!bit_of(sel, o) || (bit_of(en, o) && ready) || to)) begin
                        m_rr = (o + 1) % N;
                        m_owner = -1;
                    end
                end else begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && bit_of(req, (m_rr + k) % N)) begin
                            found = 1'b1;
                            m_owner = (m_rr + k) % N;
                        end
                    end
                end
                m_wd = (stall && !to) ? m_wd + 1 : 0;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
